// File: rtl/count_arbiter_pkg.sv
// Shared definitions for the count arbiter: FSM encoding, default slot length
// and the round-robin index helper.
package count_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int TERM_DEFAULT = 10;
    localparam int OWNER_W      = 3;

    // Index 'offset' positions after 'base', wrapped into 0..n-1 (offset <= n).
    function automatic logic [OWNER_W-1:0] rr_index(
        input logic [OWNER_W-1:0] base,
        input int                 offset,
        input int                 n
    );
        logic [OWNER_W:0] sum;
        sum = {1'b0, base} + (OWNER_W+1)'(offset);
        if (sum >= (OWNER_W+1)'(n)) begin
            sum = sum - (OWNER_W+1)'(n);
        end else begin
            sum = sum;
        end
        return sum[OWNER_W-1:0];
    endfunction

endpackage

// File: rtl/count_arbiter_slot_counter.sv
// 4-bit slot counter with synchronous clear, enable and terminal-count flag.
// Saturates at TERM so it can never run past the slot length.
module slot_counter #(
    parameter int TERM = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_i,
    input  logic       en_i,
    output logic [3:0] count_o,
    output logic       tc_o
);

    localparam logic [3:0] TERM_C = 4'(TERM);

    logic [3:0] count_q;
    logic [3:0] count_d;

    // Next count: clear wins over enable, and enable holds at TERM.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = 4'd0;
        end else if (en_i && (count_q != TERM_C)) begin
            count_d = count_q + 4'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign tc_o    = (count_q == TERM_C);

endmodule

// File: rtl/count_arbiter.sv
// Round-robin arbiter granting one requester a fixed-length counted slot,
// with early release when the owner drops its request.
module count_arbiter
    import count_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int TERM = TERM_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    output logic [NREQ-1:0]      grant,
    output logic [3:0]           count,
    output logic                 busy,
    output logic                 done,
    output logic [OWNER_W-1:0]   owner
);

    state_e               state_q;
    logic [NREQ-1:0]      grant_q;
    logic [OWNER_W-1:0]   owner_q;
    logic [OWNER_W-1:0]   last_owner_q;
    logic                 done_q;
    logic                 busy_q;

    logic [7:0]           req_ext_s;
    logic [OWNER_W-1:0]   rr_cand_s;
    logic [OWNER_W-1:0]   sel_idx_s;
    logic                 sel_valid_s;
    logic [NREQ-1:0]      grant_sel_s;
    logic                 owner_req_s;
    logic                 cnt_clr_s;
    logic                 cnt_en_s;
    logic                 cnt_tc_s;
    logic [3:0]           cnt_s;

    // Widened to 8 entries so a 3-bit index always addresses it exactly.
    assign req_ext_s   = 8'(req);
    assign owner_req_s = req_ext_s[owner_q];

    // Round-robin search starting just after the last owner.
    always_comb begin
        sel_valid_s = 1'b0;
        sel_idx_s   = 3'd0;
        rr_cand_s   = 3'd0;
        grant_sel_s = '0;
        for (int k = 1; k <= NREQ; k++) begin
            rr_cand_s = rr_index(last_owner_q, k, NREQ);
            if (!sel_valid_s && req_ext_s[rr_cand_s]) begin
                sel_valid_s = 1'b1;
                sel_idx_s   = rr_cand_s;
            end else begin
                sel_valid_s = sel_valid_s;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            grant_sel_s[i] = (sel_idx_s == 3'(i));
        end
    end

    // Counter control: runs only while the owner keeps its request and the slot is open.
    always_comb begin
        cnt_clr_s = 1'b0;
        cnt_en_s  = 1'b0;
        case (state_q)
            ST_IDLE: cnt_clr_s = 1'b1;
            ST_RUN: begin
                if (!owner_req_s || cnt_tc_s) begin
                    cnt_clr_s = 1'b1;
                end else begin
                    cnt_en_s = 1'b1;
                end
            end
            ST_DONE: cnt_clr_s = 1'b1;
            default: cnt_clr_s = 1'b1;
        endcase
    end

    slot_counter #(
        .TERM (TERM)
    ) u_slot_counter (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (cnt_clr_s),
        .en_i    (cnt_en_s),
        .count_o (cnt_s),
        .tc_o    (cnt_tc_s)
    );

    // Arbitration FSM with registered grant, busy, done and owner.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            owner_q      <= 3'd0;
            last_owner_q <= 3'(NREQ-1);
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (sel_valid_s) begin
                        state_q      <= ST_RUN;
                        grant_q      <= grant_sel_s;
                        busy_q       <= 1'b1;
                        owner_q      <= sel_idx_s;
                        last_owner_q <= sel_idx_s;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (!owner_req_s) begin
                        state_q <= ST_IDLE;
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                    end else if (cnt_tc_s) begin
                        state_q <= ST_DONE;
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign grant = grant_q;
    assign count = cnt_s;
    assign busy  = busy_q;
    assign done  = done_q;
    assign owner = owner_q;

endmodule

// File: tb/tb_count_arbiter.sv
// Randomized scoreboard bench for count_arbiter against a cycle-level
// behavioural model of the arbitration rules.
module tb_count_arbiter;
    import count_arbiter_pkg::*;

    localparam int NREQ = 4;
    localparam int TERM = TERM_DEFAULT;

    typedef struct packed {
        logic [NREQ-1:0] grant;
        logic [3:0]      count;
        logic            busy;
        logic            done;
        logic [2:0]      owner;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] grant;
    logic [3:0]      count;
    logic            busy;
    logic            done;
    logic [2:0]      owner;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    bit   mon_on = 1'b0;

    // Model state: 0 idle, 1 run, 2 done
    int m_phase, m_count, m_owner, m_last, m_grant, m_done;

    always #5 clk = ~clk;

    count_arbiter #(.NREQ(NREQ), .TERM(TERM)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .grant (grant),
        .count (count),
        .busy  (busy),
        .done  (done),
        .owner (owner)
    );

    task automatic model_step(input logic [NREQ-1:0] r, input logic rs);
        exp_t e;
        int idx;
        bit found;
        if (rs) begin
            m_phase = 0; m_count = 0; m_owner = 0; m_last = NREQ-1; m_grant = 0; m_done = 0;
        end else if (m_phase == 0) begin
            m_done = 0;
            found = 1'b0;
            for (int k = 1; k <= NREQ; k++) begin
                idx = (m_last + k) % NREQ;
                if (!found && r[idx]) begin
                    found = 1'b1;
                    m_phase = 1; m_owner = idx; m_last = idx; m_count = 0; m_grant = 1 << idx;
                end
            end
        end else if (m_phase == 1) begin
            if (!r[m_owner]) begin
                m_phase = 0; m_grant = 0; m_count = 0;
            end else if (m_count == TERM) begin
                m_phase = 2; m_grant = 0; m_count = 0; m_done = 1;
            end else begin
                m_count = m_count + 1;
            end
        end else begin
            m_phase = 0; m_done = 0;
        end
        e.grant = NREQ'(m_grant);
        e.count = 4'(m_count);
        e.busy  = (m_grant != 0);
        e.done  = (m_done != 0);
        e.owner = 3'(m_owner);
        sb_q.push_back(e);
    endtask

    task automatic drive(input logic [NREQ-1:0] r, input logic rs);
        @(negedge clk);
        req = r;
        rst = rs;
        model_step(r, rs);
        mon_on = 1'b1;
    endtask

    task automatic bound_check(input bit reached, input string name);
        total++;
        if (!reached) begin
            bad++;
            $display("FAIL %s: wait bound expired, got timeout, want condition reached", name);
        end
    endtask

    // Monitor: pops one expectation per clock and checks invariants.
    initial begin
        exp_t e;
        logic [3:0] prev_count;
        prev_count = 4'd0;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                total++;
                if (grant !== e.grant || count !== e.count || busy !== e.busy ||
                    done !== e.done || owner !== e.owner) begin
                    bad++;
                    $display("FAIL outputs @%0t: got grant=%b count=%0d busy=%b done=%b owner=%0d, want grant=%b count=%0d busy=%b done=%b owner=%0d",
                             $time, grant, count, busy, done, owner,
                             e.grant, e.count, e.busy, e.done, e.owner);
                end
                total++;
                if (!$onehot0(grant) || count > 4'(TERM) || busy !== (|grant)) begin
                    bad++;
                    $display("FAIL invariant @%0t: got grant=%b count=%0d busy=%b, want onehot0 grant, count<=%0d, busy==|grant",
                             $time, grant, count, busy, TERM);
                end
                if (done) begin
                    total++;
                    if (prev_count != 4'(TERM)) begin
                        bad++;
                        $display("FAIL done_timing @%0t: got prev count=%0d, want %0d", $time, prev_count, TERM);
                    end
                end
                prev_count = count;
            end else if (mon_on) begin
                total++;
                bad++;
                $display("FAIL scoreboard @%0t: got empty queue, want an expectation", $time);
            end
        end
    end

    initial begin
        logic [NREQ-1:0] r;
        bit reached;
        rst = 1'b1;
        req = '0;
        m_phase = 0; m_count = 0; m_owner = 0; m_last = NREQ-1; m_grant = 0; m_done = 0;

        repeat (3) drive('0, 1'b1);
        repeat (3) drive('0, 1'b0);
        // single requester full slot
        repeat (16) drive(4'b0001, 1'b0);
        repeat (3) drive(4'b0000, 1'b0);
        // all requesters rotate
        repeat (60) drive(4'b1111, 1'b0);

        // early release of requester 2 at count 5
        drive('0, 1'b1);
        reached = 1'b0;
        for (int i = 0; i < 40 && !reached; i++) begin
            if (m_phase == 1 && m_owner == 2 && m_count == 5) reached = 1'b1;
            else drive(4'b0100, 1'b0);
        end
        bound_check(reached, "wait_count5");
        drive(4'b0000, 1'b0);
        repeat (20) drive(4'b1011, 1'b0);

        // reset mid-run at count 7
        drive('0, 1'b1);
        reached = 1'b0;
        for (int i = 0; i < 40 && !reached; i++) begin
            if (m_phase == 1 && m_count == 7) reached = 1'b1;
            else drive(4'b0001, 1'b0);
        end
        bound_check(reached, "wait_count7");
        drive(4'b0001, 1'b1);
        repeat (20) drive(4'b1010, 1'b0);

        // non-owner toggling during a slot
        drive('0, 1'b1);
        for (int i = 0; i < 30; i++) drive({i[0], 3'b010}, 1'b0);
        repeat (15) drive(4'b1010, 1'b0);

        // random traffic with occasional reset
        r = '0;
        for (int c = 0; c < 1500; c++) begin
            for (int b = 0; b < NREQ; b++) begin
                if ($urandom_range(7) == 0) r[b] = ~r[b];
            end
            drive(r, ($urandom_range(199) == 0));
        end
        repeat (4) drive('0, 1'b0);

        @(posedge clk);
        #2;
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending, want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
